fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 131 +++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch with credit-limited prefetch FIFO, in-order memory responses and redirect flush.
// Optional perf counters (perf_fetched, perf_flushes) are built when FETCH_PERF_CNT_EN is defined.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 4
) (
   input  logic        clock,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_valid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        dec_ready,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic [31:0] inst_pc_plus1,
   output logic        err_spurious
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_flushes
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {BOOT, RUN, DRAIN} state_t;

   state_t        state;
   logic [31:0]   fetch_pc;
   logic [31:0]   resp_pc;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] drop_cnt;
   logic [CW-1:0] count;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [31:0]   fifo_inst [DEPTH];
   logic [31:0]   fifo_pc   [DEPTH];

   logic          rsp_ok;
   logic          push;
   logic          pop;
   logic [CW-1:0] used;
   logic [CW-1:0] drop_load;

   always_comb begin
      // A response with nothing outstanding is spurious and must not touch any state but the flag.
      rsp_ok        = imem_valid && (outstanding != '0);
      used          = count + outstanding;
      imem_req      = (state == RUN) && !redirect_valid && (used < CW'(DEPTH));
      imem_addr     = fetch_pc;
      inst_valid    = (count != '0);
      push          = rsp_ok && (drop_cnt == '0) && !redirect_valid;
      pop           = inst_valid && dec_ready && !redirect_valid;
      // Outstanding already includes responses still to be dropped, so it alone sizes the new drop window.
      drop_load     = outstanding - CW'(rsp_ok);
      inst          = inst_valid ? fifo_inst[rd_ptr] : '0;
      inst_pc       = inst_valid ? fifo_pc[rd_ptr] : '0;
      inst_pc_plus1 = inst_valid ? fifo_pc[rd_ptr] + 32'd1 : '0;
   end

   always_ff @(posedge clock) begin
      if (push) begin
         fifo_inst[wr_ptr] <= imem_rdata;
         fifo_pc[wr_ptr]   <= resp_pc;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= BOOT;
         fetch_pc     <= RESET_PC;
         resp_pc      <= RESET_PC;
         outstanding  <= '0;
         drop_cnt     <= '0;
         count        <= '0;
         rd_ptr       <= '0;
         wr_ptr       <= '0;
         err_spurious <= 1'b0;
      end else begin
         outstanding <= outstanding + CW'(imem_req) - CW'(rsp_ok);
         if (imem_valid && (outstanding == '0))
            err_spurious <= 1'b1;
         if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            resp_pc  <= redirect_pc;
            drop_cnt <= drop_load;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            state    <= (drop_load != '0) ? DRAIN : RUN;
         end else begin
            if (imem_req)
               fetch_pc <= fetch_pc + 32'd1;
            if (push) begin
               resp_pc <= resp_pc + 32'd1;
               wr_ptr  <= wr_ptr + AW'(1);
            end
            if (rsp_ok && (drop_cnt != '0))
               drop_cnt <= drop_cnt - CW'(1);
            if (pop)
               rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
            case (state)
               BOOT:    state <= RUN;
               DRAIN:   if (drop_cnt == '0) state <= RUN;
               default: state <= RUN;
            endcase
         end
      end
   end

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         perf_fetched <= '0;
         perf_flushes <= '0;
      end else begin
         perf_fetched <= perf_fetched + 32'(pop);
         perf_flushes <= perf_flushes + 32'(redirect_valid);
      end
   end
`endif

   assert property (@(posedge clock) disable iff (reset) !(push && !pop && (count == CW'(DEPTH))));

endmodule
